// File: rtl/calibration_pkg.sv
// Shared calibration types: step FSM state encoding, accumulator update mode,
// sequencer state encoding and the default strand colours.
package calibration_pkg;

    typedef enum logic [2:0] {
        STEP_IDLE       = 3'd0,
        STEP_SETTLE     = 3'd1,
        STEP_CAPTURE    = 3'd2,
        STEP_ACCUMULATE = 3'd3,
        STEP_FINISH     = 3'd4
    } calibration_step_state_t;

    typedef enum logic {
        UPDATE_ACCUMULATE = 1'b0,
        UPDATE_OVERWRITE  = 1'b1
    } update_mode_t;

    typedef enum logic [2:0] {
        SEQ_IDLE         = 3'd0,
        SEQ_PUSH         = 3'd1,
        SEQ_WAIT_DISPLAY = 3'd2,
        SEQ_TRIGGER      = 3'd3,
        SEQ_WAIT_STEP    = 3'd4,
        SEQ_DONE         = 3'd5
    } seq_state_t;

    localparam logic [23:0] DEFAULT_COLOR_0 = 24'h00FF00;
    localparam logic [23:0] DEFAULT_COLOR_1 = 24'h0000FF;

endpackage

// File: rtl/bitplane_color_lut.sv
// Combinational mapping from an LED index and the active bit plane to a strand
// colour; LEDs past the physical strand, or a blanked sequencer, give black.
module bitplane_color_lut
    import calibration_pkg::*;
#(
    parameter int          NUM_LEDS          = 50,
    parameter int          LED_ADDRESS_WIDTH = 10,
    parameter int          BIT_INDEX_WIDTH   = 3,
    parameter logic [23:0] COLOR_0           = DEFAULT_COLOR_0,
    parameter logic [23:0] COLOR_1           = DEFAULT_COLOR_1
)(
    input  logic [LED_ADDRESS_WIDTH-1:0] i_led_index,
    input  logic [BIT_INDEX_WIDTH-1:0]   i_bit_index,
    input  logic                         i_blank,
    output logic [23:0]                  o_color
);

    logic [LED_ADDRESS_WIDTH-1:0] w_shifted;
    logic                         w_out_of_range;

    // A shift keeps the bit select free of index-width mismatches.
    assign w_shifted      = i_led_index >> i_bit_index;
    assign w_out_of_range = 32'(i_led_index) >= NUM_LEDS;

    always_comb begin
        o_color = w_shifted[0] ? COLOR_1 : COLOR_0;
        if (i_blank || w_out_of_range) begin
            o_color = '0;
        end
    end

endmodule

// File: rtl/calibration_pattern_sequencer.sv
// Steps the strand through one binary bit-plane pattern per address bit and
// hands each latched pattern to calibration_step_fsm for capture.
module calibration_pattern_sequencer
    import calibration_pkg::*;
#(
    parameter int          NUM_LEDS          = 50,
    parameter int          LED_ADDRESS_WIDTH = 10,
    parameter int          NUM_BITS          = 6,
    parameter logic [23:0] COLOR_0           = DEFAULT_COLOR_0,
    parameter logic [23:0] COLOR_1           = DEFAULT_COLOR_1,
    localparam int         BIT_INDEX_WIDTH   = $clog2(NUM_BITS + 1)
)(
    input  logic                         clk_pixel,
    input  logic                         rst,
    input  logic                         start_in,
    input  logic                         abort_in,
    input  logic                         led_request_in,
    input  logic [LED_ADDRESS_WIDTH-1:0] led_index_in,
    output logic [23:0]                  color_out,
    output logic                         color_valid_out,
    output logic                         strand_start_out,
    input  logic                         strand_done_in,
    input  logic [2:0]                   step_state_in,
    output logic                         start_step_out,
    output logic                         should_overwrite_out,
    output logic [BIT_INDEX_WIDTH-1:0]   bit_index_out,
    output logic                         busy_out,
    output logic                         done_out
);

    localparam logic [BIT_INDEX_WIDTH-1:0] LAST_BIT = BIT_INDEX_WIDTH'(NUM_BITS - 1);

    seq_state_t                 r_state;
    logic [BIT_INDEX_WIDTH-1:0] r_bit_index;
    logic                       r_start_d;
    logic                       r_strand_start;
    logic                       r_start_step;
    logic                       r_overwrite;
    logic                       r_done;
    logic [23:0]                r_color;
    logic                       r_color_valid;
    logic                       w_start_edge;
    logic                       w_blank;
    logic [23:0]                w_lut_color;

    assign w_start_edge = start_in & ~r_start_d;
    assign w_blank      = (r_state == SEQ_IDLE) || (r_state == SEQ_DONE);

    bitplane_color_lut #(
        .NUM_LEDS          (NUM_LEDS),
        .LED_ADDRESS_WIDTH (LED_ADDRESS_WIDTH),
        .BIT_INDEX_WIDTH   (BIT_INDEX_WIDTH),
        .COLOR_0           (COLOR_0),
        .COLOR_1           (COLOR_1)
    ) u_lut (
        .i_led_index (led_index_in),
        .i_bit_index (r_bit_index),
        .i_blank     (w_blank),
        .o_color     (w_lut_color)
    );

    // The start history updates every cycle, so an edge eaten by abort or busy is gone for good.
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            r_state        <= SEQ_IDLE;
            r_bit_index    <= '0;
            r_start_d      <= 1'b0;
            r_strand_start <= 1'b0;
            r_start_step   <= 1'b0;
            r_overwrite    <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_start_d <= start_in;
            if (abort_in) begin
                r_state        <= SEQ_IDLE;
                r_strand_start <= 1'b0;
                r_start_step   <= 1'b0;
                r_overwrite    <= 1'b0;
                r_done         <= 1'b0;
            end else begin
                case (r_state)
                    SEQ_IDLE: if (w_start_edge) begin
                        r_bit_index    <= '0;
                        r_strand_start <= 1'b1;
                        r_state        <= SEQ_PUSH;
                    end
                    SEQ_PUSH: begin
                        r_strand_start <= 1'b0;
                        r_state        <= SEQ_WAIT_DISPLAY;
                    end
                    SEQ_WAIT_DISPLAY: if (strand_done_in) begin
                        r_start_step <= 1'b1;
                        r_overwrite  <= (r_bit_index == '0);
                        r_state      <= SEQ_TRIGGER;
                    end
                    SEQ_TRIGGER: if (step_state_in != STEP_IDLE) begin
                        r_start_step <= 1'b0;
                        r_overwrite  <= 1'b0;
                        r_state      <= SEQ_WAIT_STEP;
                    end
                    // Leaving through WAIT_STEP keeps start_step low between captures.
                    SEQ_WAIT_STEP: if (step_state_in == STEP_IDLE) begin
                        if (r_bit_index == LAST_BIT) begin
                            r_done  <= 1'b1;
                            r_state <= SEQ_DONE;
                        end else begin
                            r_bit_index    <= r_bit_index + BIT_INDEX_WIDTH'(1);
                            r_strand_start <= 1'b1;
                            r_state        <= SEQ_PUSH;
                        end
                    end
                    SEQ_DONE: begin
                        r_done  <= 1'b0;
                        r_state <= SEQ_IDLE;
                    end
                    default: r_state <= SEQ_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            r_color       <= '0;
            r_color_valid <= 1'b0;
        end else begin
            r_color_valid <= led_request_in;
            r_color       <= led_request_in ? w_lut_color : '0;
        end
    end

    assign color_out            = r_color;
    assign color_valid_out      = r_color_valid;
    assign strand_start_out     = r_strand_start;
    assign start_step_out       = r_start_step;
    assign should_overwrite_out = r_overwrite;
    assign bit_index_out        = r_bit_index;
    assign busy_out             = (r_state != SEQ_IDLE);
    assign done_out             = r_done;

endmodule

// File: tb/tb_calibration_pattern_sequencer.sv
// Directed bench for calibration_pattern_sequencer with a strand driver model
// and a calibration step model.
module tb_calibration_pattern_sequencer;

    logic        clk_pixel = 1'b0;
    logic        rst;
    logic        start_in;
    logic        abort_in;
    logic        led_request_in;
    logic [9:0]  led_index_in;
    logic [23:0] color_out;
    logic        color_valid_out;
    logic        strand_start_out;
    logic        strand_done_in;
    logic [2:0]  step_state_in = 3'd0;
    logic        start_step_out;
    logic        should_overwrite_out;
    logic [2:0]  bit_index_out;
    logic        busy_out;
    logic        done_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_pixel = ~clk_pixel;

    calibration_pattern_sequencer dut (
        .clk_pixel            (clk_pixel),
        .rst                  (rst),
        .start_in             (start_in),
        .abort_in             (abort_in),
        .led_request_in       (led_request_in),
        .led_index_in         (led_index_in),
        .color_out            (color_out),
        .color_valid_out      (color_valid_out),
        .strand_start_out     (strand_start_out),
        .strand_done_in       (strand_done_in),
        .step_state_in        (step_state_in),
        .start_step_out       (start_step_out),
        .should_overwrite_out (should_overwrite_out),
        .bit_index_out        (bit_index_out),
        .busy_out             (busy_out),
        .done_out             (done_out)
    );

    // Strand driver model: frame latched 4 cycles after a push request.
    logic drv_en   = 1'b1;
    logic drv_done = 1'b0;
    logic man_done = 1'b0;
    int   drv_cnt  = 0;
    assign strand_done_in = drv_done | man_done;

    always @(posedge clk_pixel) begin
        drv_done <= 1'b0;
        if (drv_cnt != 0) begin
            drv_cnt <= drv_cnt - 1;
            if (drv_cnt == 1) drv_done <= 1'b1;
        end else if (drv_en && strand_start_out) begin
            drv_cnt <= 4;
        end
    end

    // Step model: leaves IDLE 3 cycles after a start rise, returns 20 cycles later.
    logic step_prev_p = 1'b0;
    int   step_cnt    = 0;

    always @(posedge clk_pixel) begin
        step_prev_p <= start_step_out;
        if (step_cnt != 0) begin
            step_cnt <= step_cnt - 1;
            if (step_cnt == 21) step_state_in <= 3'd1;
            if (step_cnt == 1)  step_state_in <= 3'd0;
        end else if (start_step_out && !step_prev_p) begin
            step_cnt <= 23;
        end
    end

    // Event counters sampled away from the active edge.
    logic       mon_strand_prev = 1'b0;
    logic       mon_step_prev   = 1'b0;
    int         n_strand_rise   = 0;
    int         n_strand_hi     = 0;
    int         n_step_rise     = 0;
    int         n_ow_rise       = 0;
    int         n_ow_orphan     = 0;
    int         n_done          = 0;
    logic [2:0] last_rise_bit   = 3'd7;
    logic       last_rise_ow    = 1'b0;

    always @(negedge clk_pixel) begin
        mon_strand_prev <= strand_start_out;
        mon_step_prev   <= start_step_out;
        if (strand_start_out) n_strand_hi <= n_strand_hi + 1;
        if (strand_start_out && !mon_strand_prev) n_strand_rise <= n_strand_rise + 1;
        if (start_step_out && !mon_step_prev) begin
            n_step_rise   <= n_step_rise + 1;
            last_rise_bit <= bit_index_out;
            last_rise_ow  <= should_overwrite_out;
            if (should_overwrite_out) n_ow_rise <= n_ow_rise + 1;
        end
        if (should_overwrite_out && !start_step_out) n_ow_orphan <= n_ow_orphan + 1;
        if (done_out) n_done <= n_done + 1;
    end

    task automatic pulse_start();
        @(negedge clk_pixel);
        start_in = 1'b1;
        @(negedge clk_pixel);
        start_in = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (!done_out && c < 3000) begin
            @(negedge clk_pixel);
            c++;
        end
        n_checks++;
        if (done_out !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done_timeout: done_out=%b after %0d cycles, required 1", name, done_out, c);
        end
        repeat (2) @(negedge clk_pixel);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_pixel);
        n_checks++;
        if ({color_out, color_valid_out, strand_start_out, start_step_out, should_overwrite_out,
             bit_index_out, busy_out, done_out} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: color=%h valid=%b strand=%b step=%b ow=%b bit=%0d busy=%b done=%b, required all 0",
                     color_out, color_valid_out, strand_start_out, start_step_out, should_overwrite_out,
                     bit_index_out, busy_out, done_out);
        end
        rst = 1'b0;
        @(negedge clk_pixel);
        n_checks++;
        if (busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b, required 0", busy_out);
        end
    endtask

    task automatic test_full_run();
        int b_sr = n_strand_rise;
        int b_sh = n_strand_hi;
        int b_st = n_step_rise;
        int b_ow = n_ow_rise;
        int b_oo = n_ow_orphan;
        int b_dn = n_done;
        pulse_start();
        n_checks++;
        if (busy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL run_busy: busy=%b, required 1", busy_out);
        end
        wait_done("full_run");
        n_checks++;
        if (n_strand_rise - b_sr !== 6) begin
            n_fail++;
            $display("FAIL run_strand_pulses: got %0d, required 6", n_strand_rise - b_sr);
        end
        n_checks++;
        if (n_strand_hi - b_sh !== 6) begin
            n_fail++;
            $display("FAIL run_strand_width: high cycles %0d, required 6", n_strand_hi - b_sh);
        end
        n_checks++;
        if (n_step_rise - b_st !== 6) begin
            n_fail++;
            $display("FAIL run_step_rises: got %0d, required 6", n_step_rise - b_st);
        end
        n_checks++;
        if (n_ow_rise - b_ow !== 1) begin
            n_fail++;
            $display("FAIL run_overwrite_count: got %0d, required 1", n_ow_rise - b_ow);
        end
        n_checks++;
        if (n_ow_orphan - b_oo !== 0) begin
            n_fail++;
            $display("FAIL run_overwrite_orphan: got %0d, required 0", n_ow_orphan - b_oo);
        end
        n_checks++;
        if (n_done - b_dn !== 1) begin
            n_fail++;
            $display("FAIL run_done_count: got %0d, required 1", n_done - b_dn);
        end
        n_checks++;
        if (busy_out !== 1'b0 || bit_index_out !== 3'd5) begin
            n_fail++;
            $display("FAIL run_end_state: busy=%b bit=%0d, required busy 0 bit 5", busy_out, bit_index_out);
        end
    endtask

    task automatic test_idle_request();
        @(negedge clk_pixel);
        led_request_in = 1'b1;
        led_index_in   = 10'd5;
        @(negedge clk_pixel);
        led_request_in = 1'b0;
        n_checks++;
        if (color_out !== 24'h000000 || color_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_request: color=%h valid=%b, required 000000 valid 1", color_out, color_valid_out);
        end
    endtask

    task automatic test_color();
        logic [9:0]  idx_tab [4] = '{10'd4, 10'd3, 10'd49, 10'd50};
        logic [23:0] exp_tab [4] = '{24'h0000FF, 24'h00FF00, 24'h00FF00, 24'h000000};
        int c = 0;
        pulse_start();
        while (bit_index_out !== 3'd2 && c < 1000) begin
            @(negedge clk_pixel);
            c++;
        end
        n_checks++;
        if (bit_index_out !== 3'd2) begin
            n_fail++;
            $display("FAIL color_reach_bit2: bit=%0d, required 2", bit_index_out);
        end
        led_request_in = 1'b1;
        led_index_in   = idx_tab[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_pixel);
            n_checks++;
            if (color_out !== exp_tab[i] || color_valid_out !== 1'b1) begin
                n_fail++;
                $display("FAIL color_idx%0d: color=%h valid=%b, required %h valid 1",
                         idx_tab[i], color_out, color_valid_out, exp_tab[i]);
            end
            if (i < 3) led_index_in = idx_tab[i + 1];
            else       led_request_in = 1'b0;
        end
        @(negedge clk_pixel);
        n_checks++;
        if (color_valid_out !== 1'b0 || color_out !== 24'h0) begin
            n_fail++;
            $display("FAIL color_idle_valid: valid=%b color=%h, required 0", color_valid_out, color_out);
        end
        wait_done("color_run");
    endtask

    task automatic test_abort();
        int c    = 0;
        int b_dn = n_done;
        int b_st;
        pulse_start();
        while (!(bit_index_out === 3'd3 && step_state_in !== 3'd0 && start_step_out === 1'b0) && c < 2000) begin
            @(negedge clk_pixel);
            c++;
        end
        abort_in = 1'b1;
        @(negedge clk_pixel);
        abort_in = 1'b0;
        n_checks++;
        if (busy_out !== 1'b0 || start_step_out !== 1'b0 || strand_start_out !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b step=%b strand=%b, required 0 0 0", busy_out, start_step_out, strand_start_out);
        end
        n_checks++;
        if (bit_index_out !== 3'd3) begin
            n_fail++;
            $display("FAIL abort_bit_held: bit=%0d, required 3", bit_index_out);
        end
        c = 0;
        while (step_cnt != 0 && c < 100) begin
            @(negedge clk_pixel);
            c++;
        end
        repeat (5) @(negedge clk_pixel);
        n_checks++;
        if (n_done - b_dn !== 0 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: done pulses %0d busy=%b, required 0 0", n_done - b_dn, busy_out);
        end
        b_st = n_step_rise;
        pulse_start();
        c = 0;
        while (n_step_rise == b_st && c < 500) begin
            @(negedge clk_pixel);
            c++;
        end
        n_checks++;
        if (last_rise_bit !== 3'd0 || last_rise_ow !== 1'b1 || n_step_rise == b_st) begin
            n_fail++;
            $display("FAIL abort_restart: first step bit=%0d overwrite=%b, required bit 0 overwrite 1",
                     last_rise_bit, last_rise_ow);
        end
        wait_done("abort_restart");
    endtask

    task automatic test_start_held();
        int b_sr;
        int b_sh;
        @(negedge clk_pixel);
        start_in = 1'b1;
        wait_done("held_run");
        b_sr = n_strand_rise;
        repeat (60) @(negedge clk_pixel);
        n_checks++;
        if (busy_out !== 1'b0 || n_strand_rise - b_sr !== 0) begin
            n_fail++;
            $display("FAIL start_held_rerun: busy=%b new pushes %0d, required 0 0", busy_out, n_strand_rise - b_sr);
        end
        start_in = 1'b0;
        repeat (2) @(negedge clk_pixel);
        b_sh = n_strand_hi;
        start_in = 1'b1;
        abort_in = 1'b1;
        @(negedge clk_pixel);
        abort_in = 1'b0;
        repeat (3) @(negedge clk_pixel);
        n_checks++;
        if (busy_out !== 1'b0 || n_strand_hi - b_sh !== 0) begin
            n_fail++;
            $display("FAIL start_with_abort: busy=%b pushes %0d, required 0 0", busy_out, n_strand_hi - b_sh);
        end
        start_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        int c    = 0;
        int b_st;
        int b_dn;
        int b_sh;
        pulse_start();
        while (bit_index_out !== 3'd1 && c < 1000) begin
            @(negedge clk_pixel);
            c++;
        end
        drv_en = 1'b0;
        repeat (3) @(negedge clk_pixel);
        b_st = n_step_rise;
        b_dn = n_done;
        rst  = 1'b1;
        @(negedge clk_pixel);
        rst = 1'b0;
        n_checks++;
        if ({color_out, color_valid_out, strand_start_out, start_step_out, should_overwrite_out,
             bit_index_out, busy_out, done_out} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: color=%h valid=%b strand=%b step=%b ow=%b bit=%0d busy=%b done=%b, required all 0",
                     color_out, color_valid_out, strand_start_out, start_step_out, should_overwrite_out,
                     bit_index_out, busy_out, done_out);
        end
        b_sh     = n_strand_hi;
        man_done = 1'b1;
        @(negedge clk_pixel);
        man_done = 1'b0;
        repeat (10) @(negedge clk_pixel);
        n_checks++;
        if (busy_out !== 1'b0 || n_step_rise - b_st !== 0 || n_done - b_dn !== 0 || n_strand_hi - b_sh !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_late_done: busy=%b steps %0d done %0d pushes %0d, required all 0",
                     busy_out, n_step_rise - b_st, n_done - b_dn, n_strand_hi - b_sh);
        end
        drv_en = 1'b1;
    endtask

    initial begin
        rst            = 1'b1;
        start_in       = 1'b0;
        abort_in       = 1'b0;
        led_request_in = 1'b0;
        led_index_in   = 10'd0;
        test_reset();
        test_full_run();
        test_idle_request();
        test_color();
        test_abort();
        test_start_held();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calibration_pattern_sequencer.md
Name: calibration_pattern_sequencer

Overview:
Drives the LED strand through the binary-coded calibration patterns, one per address bit. Each LED shows COLOR_1 or COLOR_0 according to bit k of its own index. After the pattern for bit k is latched on the strand, the block triggers one calibration_step_fsm capture and waits for it to finish before moving to bit k+1. It is the transmit side of the per-pixel address accumulation: it sits between the top-level user controls, the LED strand driver and calibration_step_fsm.

Parameters:
NUM_LEDS, 50, number of physical LEDs; indices at or above this are driven dark.
LED_ADDRESS_WIDTH, 10, width of the LED index bus; must match calibration_step_fsm.
NUM_BITS, 6, number of bit-plane steps; must be at least 1, no greater than LED_ADDRESS_WIDTH, and at least $clog2(NUM_LEDS).
COLOR_0, 24'h00FF00, strand colour for an LED whose current bit is 0 (detected as detect_0).
COLOR_1, 24'h0000FF, strand colour for an LED whose current bit is 1 (detected as detect_1).
BIT_INDEX_WIDTH (localparam), $clog2(NUM_BITS+1).

Ports:
clk_pixel  input  1  pixel clock.
rst  input  1  synchronous, active-high reset.
start_in  input  1  start a full calibration; rising-edge detected.
abort_in  input  1  level; forces the block back to IDLE.
led_request_in  input  1  driver requests the colour for led_index_in.
led_index_in  input  LED_ADDRESS_WIDTH  index of the requested LED.
color_out  output  24  colour answering the request.
color_valid_out  output  1  one-cycle strobe qualifying color_out.
strand_start_out  output  1  one-cycle pulse telling the driver to push a full strand.
strand_done_in  input  1  pulse from the driver: the strand frame is latched (displayed_frame_valid).
step_state_in  input  3  calibration_step_state_t from calibration_step_fsm.
start_step_out  output  1  drives start_calibration_step.
should_overwrite_out  output  1  drives should_overwrite_latch.
bit_index_out  output  BIT_INDEX_WIDTH  bit currently being displayed or captured.
busy_out  output  1  high in every state except IDLE.
done_out  output  1  one-cycle pulse when every bit has been captured.

Behaviour:
- Reset values: all outputs 0, state IDLE, bit index 0, color_out 0.
- Colour path: runs in every state and is registered with 1-cycle latency.
  - Cycle after led_request_in: color_valid_out=1.
  - color_out = 0 if led_index_in >= NUM_LEDS, or if the state is IDLE or DONE.
  - Otherwise color_out = led_index_in[bit_index] ? COLOR_1 : COLOR_0.
  - Back-to-back requests on consecutive cycles must be answered on consecutive cycles.
- States:
  - IDLE: on a start_in rising edge, bit_index <= 0 and go to PUSH.
  - PUSH: assert strand_start_out for exactly 1 cycle, then go to WAIT_DISPLAY.
  - WAIT_DISPLAY: on strand_done_in go to TRIGGER. Requests from the driver are served while in this state.
  - TRIGGER: hold start_step_out=1 and should_overwrite_out=(bit_index==0) until step_state_in != IDLE, then go to WAIT_STEP.
  - WAIT_STEP: start_step_out=0 and should_overwrite_out=0. When step_state_in==IDLE:
    - if bit_index == NUM_BITS-1, go to DONE;
    - else bit_index <= bit_index+1 and go to PUSH.
  - DONE: pulse done_out for 1 cycle, then go to IDLE. A final dark strand is not pushed.
- start_step_out must be low for at least 1 cycle between steps, because calibration_step_fsm is edge-triggered. WAIT_STEP guarantees this.
- abort_in in any state: next state IDLE; start_step_out, should_overwrite_out and strand_start_out drop the same cycle the state register updates. bit_index is held, for debug.
- abort_in and start_in together: abort wins, and the start edge is discarded.
- start_in while busy_out=1: ignored.
- strand_done_in outside WAIT_DISPLAY: ignored.
- step_state_in already non-IDLE on entry to TRIGGER: advance after 1 cycle of start_step_out.
- rst mid-sequence: everything returns to reset values on the next edge, and no done_out is emitted.

Decomposition:
- calibration_pkg (shared package): calibration_step_state_t (moved out of calibration_step_fsm), update_mode_t, and the default COLOR_0/COLOR_1 constants.
- Sub-module bitplane_color_lut: combinational index/bit-to-colour mapping, including the NUM_LEDS blanking. The FSM and the response register stay in the top module.

Test Plan:
- Full run with NUM_BITS=6, NUM_LEDS=50, and a step model that leaves IDLE 3 cycles after a start_step_out rise and returns 20 cycles later -> exactly 6 strand_start_out pulses and 6 start_step_out rises; should_overwrite_out=1 only on the first; a single done_out.
- Colour check at bit_index=2, requests for indices 4, 3, 49, 50 -> color_out 24'h0000FF, 24'h00FF00, 24'h00FF00, 24'h000000 on the 4 following cycles, each with color_valid_out=1.
- Request in IDLE for index 5 -> color_out=0, color_valid_out=1 one cycle later.
- abort_in asserted in WAIT_STEP at bit 3 -> IDLE next cycle, start_step_out=0, no done_out; a fresh start_in edge restarts at bit 0 with overwrite.
- start_in held high across the end of a run -> no second run without a new rising edge; start_in and abort_in in the same cycle -> stays in IDLE.
- rst asserted during WAIT_DISPLAY -> all outputs 0 and busy_out=0 on the next cycle; a later strand_done_in has no effect.
